bit_4_cnt_10: RTL and testbench
===============================

# bit_4_cnt_10

Synchronous modulo-10 (decade) counter with a 4-bit binary count output and a carry-out flag. It counts 0 to 9 and wraps, asserting `cout` during the terminal count so instances can be cascaded into multi-digit BCD counters or used as a divide-by-10 tick source. It is a leaf block with a single clock domain and no handshake.

## Interface
Parameters:
- `WIDTH`, default 4: count register width. Must satisfy 2^WIDTH >= `MODULUS`.
- `MODULUS`, default 10: number of states. The counter runs from 0 to `MODULUS`-1. Legal range is 2 to 2^WIDTH.
- `PRESCALE`, default 1: number of clocks per count step. Legal range is 1 or more; 1 means the counter steps every clock.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `cnt_out` output `WIDTH` [3:0]: current count, unsigned binary.
- `cout` output 1: carry/terminal-count flag.

## Operation
- Internal step enable `tick`:
  - With `PRESCALE`=1, `tick` is constantly 1.
  - Otherwise a prescaler counter runs 0 to `PRESCALE`-1, and `tick`=1 when it equals `PRESCALE`-1.
- On each rising edge with `tick`=1:
  - If `cnt_out`==`MODULUS`-1, `cnt_out` becomes 0.
  - Otherwise `cnt_out` increments by 1.
- With `tick`=0, `cnt_out` holds.
- `cout` = (`cnt_out`==`MODULUS`-1) AND `tick`.
  - It is decoded only from registered state, so it is glitch-free.
  - It is high for exactly one clock per full count cycle.
- Sequence with default parameters: 0,1,2,...,9,0,...
- `cout`=1 exactly while `cnt_out`=9.
- Arithmetic is unsigned, modulo `MODULUS`. No count value of `MODULUS` or above is reachable in normal operation.
- There is no enable, load or direction input. The counter is free-running after reset.

## Timing
- Reset assertion (`rst_n`=0) immediately forces `cnt_out`=0, `cout`=0 and the prescaler to 0, without waiting for a clock edge.
- Reset deassertion is synchronized by the user. The first increment happens on the first rising edge after `rst_n` rises, giving `cnt_out`=1 after that edge when `PRESCALE`=1.
- Latency: `cnt_out` changes one clock edge after the tick condition. `cout` is combinational from the register state, with zero added latency.
- Wrap: the edge taken while `cnt_out`=9 produces `cnt_out`=0 and `cout`=0 in the same cycle.
- Period: `cout` repeats every `MODULUS`*`PRESCALE` clocks, which is 10 clocks by default.
- Reset mid-count, including while `cout`=1: all outputs clear immediately, and the count restarts from 0 on release.

## Configuration
- Macro `BIT_4_CNT_10_ILLEGAL_RECOVER_EN`.
- Defined:
  - Any `cnt_out` value >= `MODULUS` (from corruption, X-injection or force) is replaced with 0 on the next rising edge, regardless of `tick`.
  - `cout` stays 0 while the count is illegal.
- Undefined:
  - No recovery logic is built.
  - An illegal value increments on each tick and wraps at 2^WIDTH back to 0, then resumes normal counting.
  - `cout` stays 0 until 9 is reached again.

## Test plan
- Hold `rst_n`=0 for 100 ns with a 20 ns clock: `cnt_out`=0 and `cout`=0 throughout.
- Release reset, then run 25 clocks: `cnt_out` follows 1..9,0..9,0..5. `cout`=1 only in the two cycles where `cnt_out`=9.
- Run free for 200 µs (10000 clocks): exactly 1000 `cout` pulses, each one clock wide and spaced 10 clocks apart.
- Assert `rst_n`=0 between clock edges while `cnt_out`=7: outputs go to 0 before the next edge. After release, counting restarts at 1.
- With `MODULUS`=10 and `PRESCALE`=3: each count value lasts 3 clocks. `cout` is a single-clock pulse on the third clock of `cnt_out`=9, with a 30-clock period.
- With the macro defined, force `cnt_out`=13 and release: the next edge gives 0. With the macro undefined, the next edges give 14, 15, 0, 1.

Source files
------------

// File: rtl/bit_4_cnt_10.sv
// Free-running modulo-MODULUS counter with optional prescaler and terminal-count carry.
// Optional macro BIT_4_CNT_10_ILLEGAL_RECOVER_EN forces out-of-range counts back to 0.
module bit_4_cnt_10 #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] cnt_out,
    output logic             cout
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic             tick;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    generate
        if (PRESCALE == 1) begin : g_no_pre
            assign tick = 1'b1;
        end else begin : g_pre
            localparam int            PW    = $clog2(PRESCALE);
            localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pre_q, pre_d;

            always_comb begin
                pre_d = (pre_q == PLAST) ? '0 : pre_q + PW'(1);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pre_q <= '0;
                else        pre_q <= pre_d;
            end

            assign tick = (pre_q == PLAST);
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
`ifdef BIT_4_CNT_10_ILLEGAL_RECOVER_EN
        // Out-of-range state is scrubbed immediately, independent of the prescaler.
        if (32'(cnt_q) >= MODULUS) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + WIDTH'(1);
        end
`else
        // An illegal value simply counts up and wraps at 2^WIDTH.
        if (tick) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + WIDTH'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_out = cnt_q;
    assign cout    = (cnt_q == LAST) & tick;

endmodule

// File: tb/tb_bit_4_cnt_10.sv
// Directed bench for bit_4_cnt_10: default decade counter plus a PRESCALE=3 instance.
// Honours BIT_4_CNT_10_ILLEGAL_RECOVER_EN for the illegal-state expectations.
module tb_bit_4_cnt_10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cnt, cnt3;
    logic       cout, cout3;

    int n_vec = 0;
    int n_err = 0;

    bit_4_cnt_10 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt_out(cnt),
        .cout   (cout)
    );

    bit_4_cnt_10 #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt_out(cnt3),
        .cout   (cout3)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        int pulses, last, bad, found;
        int exp_ill[4];

        rst_n = 1'b0;
        // Reset held for 100 ns: everything stays at 0.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_cnt", cnt, 0);
            chk("rst_cout", cout, 0);
            chk("rst_cnt3", cnt3, 0);
            chk("rst_cout3", cout3, 0);
        end
        rst_n = 1'b1;

        // 25 clocks: 1..9,0..9,0..5 with cout on the 9s.
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            chk("seq_cnt", cnt, k % 10);
            chk("seq_cout", cout, (k % 10) == 9);
        end

        // 10000 free-running clocks: 1000 single-cycle pulses, 10 apart.
        pulses = 0; last = -1; bad = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (cout) begin
                pulses++;
                if (last >= 0 && (c - last) != 10) bad++;
                if (cnt !== 4'd9) bad++;
                last = c;
            end
        end
        chk("run_pulses", pulses, 1000);
        chk("run_spacing", bad, 0);

        // Reset between edges while cout is high.
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                @(negedge clk);
                if (cnt == 4'd9) found = 1;
            end
        end
        chk("find9", found, 1);
        chk("pre9_cout", cout, 1);
        #5 rst_n = 1'b0;
        #1;
        chk("mid9_cnt", cnt, 0);
        chk("mid9_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset between edges while count is 7.
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                @(negedge clk);
                if (cnt == 4'd7) found = 1;
            end
        end
        chk("find7", found, 1);
        #5 rst_n = 1'b0;
        #1;
        chk("mid7_cnt", cnt, 0);
        chk("mid7_cout", cout, 0);
        chk("mid7_cnt3", cnt3, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Restart: default counts k%10; prescaled holds each value 3 clocks, pulses at k=29,59.
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            chk("rst_cnt_k", cnt, k % 10);
            chk("rst_cout_k", cout, (k % 10) == 9);
            chk("pre_cnt", cnt3, (k / 3) % 10);
            chk("pre_cout", cout3, (k % 30) == 29);
        end

        // Illegal state injection.
`ifdef BIT_4_CNT_10_ILLEGAL_RECOVER_EN
        exp_ill = '{0, 1, 2, 3};
`else
        exp_ill = '{14, 15, 0, 1};
`endif
        force dut.cnt_q = 4'd13;
        #1;
        chk("ill_cnt", cnt, 13);
        chk("ill_cout", cout, 0);
        release dut.cnt_q;
        #1;
        chk("ill_hold", cnt, 13);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ill_next", cnt, exp_ill[i]);
            chk("ill_next_cout", cout, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
